// File: rtl/life_pkg.sv
// life_pkg: shared state encoding and default rule masks for the life engine.
package life_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SWEEP  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Bit n set means "alive next" for a cell with n live neighbours (B3/S23).
    localparam logic [8:0] LIFE_BIRTH_DEFAULT = 9'b000001000;
    localparam logic [8:0] LIFE_SURV_DEFAULT  = 9'b000001100;

endpackage

// File: rtl/life_row_next.sv
// life_row_next: next-generation value of one grid row from its row above,
// itself and the row below, plus the live-cell count of the result.
module life_row_next #(
    parameter int unsigned GRID_W = 32
) (
    input  logic [GRID_W-1:0]          up,
    input  logic [GRID_W-1:0]          mid,
    input  logic [GRID_W-1:0]          down,
    input  logic                       wrap,
    input  logic [8:0]                 birth_mask,
    input  logic [8:0]                 surv_mask,
    output logic [GRID_W-1:0]          next_row,
    output logic [$clog2(GRID_W+1)-1:0] pop_count
);
    localparam int unsigned PCW = $clog2(GRID_W + 1);

    logic [GRID_W-1:0] up_w, up_e, mid_w, mid_e, down_w, down_e;
    logic [3:0]        n;

    // Bit c of a "west" vector holds the neighbour at column c-1; edges wrap or read dead.
    function automatic logic [GRID_W-1:0] from_west(input logic [GRID_W-1:0] r, input logic w);
        return {r[GRID_W-2:0], w & r[GRID_W-1]};
    endfunction

    function automatic logic [GRID_W-1:0] from_east(input logic [GRID_W-1:0] r, input logic w);
        return {w & r[0], r[GRID_W-1:1]};
    endfunction

    assign up_w   = from_west(up, wrap);
    assign up_e   = from_east(up, wrap);
    assign mid_w  = from_west(mid, wrap);
    assign mid_e  = from_east(mid, wrap);
    assign down_w = from_west(down, wrap);
    assign down_e = from_east(down, wrap);

    // Per-column neighbour count, rule lookup and running popcount.
    always_comb begin
        next_row  = '0;
        pop_count = '0;
        n         = '0;
        for (int c = 0; c < GRID_W; c++) begin
            n = 4'(up_w[c]) + 4'(up[c]) + 4'(up_e[c])
              + 4'(mid_w[c]) + 4'(mid_e[c])
              + 4'(down_w[c]) + 4'(down[c]) + 4'(down_e[c]);
            next_row[c] = mid[c] ? surv_mask[n] : birth_mask[n];
            pop_count   = pop_count + PCW'(next_row[c]);
        end
    end

endmodule

// File: rtl/life_engine.sv
// life_engine: Game-of-Life core. Sweeps one row per cycle into a shadow grid,
// then commits it in one cycle. Macro LIFE_RULE_EN adds run-time birth/survival
// mask inputs; without it the rule is fixed at B3/S23.
module life_engine
    import life_pkg::*;
#(
    parameter int unsigned GRID_W   = 32,
    parameter int unsigned GRID_H   = 24,
    parameter int unsigned GEN_W    = 16,
    parameter int unsigned STEP_DIV = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               step,
    input  logic                               run,
    input  logic                               wrap,
    input  logic                               clear,
    input  logic                               wr_en,
    input  logic [$clog2(GRID_W)-1:0]          wr_x,
    input  logic [$clog2(GRID_H)-1:0]          wr_y,
    input  logic                               wr_val,
    input  logic [$clog2(GRID_W)-1:0]          rd_x,
    input  logic [$clog2(GRID_H)-1:0]          rd_y,
`ifdef LIFE_RULE_EN
    input  logic [8:0]                         birth_mask,
    input  logic [8:0]                         surv_mask,
`endif
    output logic                               rd_cell,
    output logic                               busy,
    output logic                               done,
    output logic [GEN_W-1:0]                   gen_count,
    output logic [$clog2(GRID_W*GRID_H+1)-1:0] population
);
    localparam int unsigned XW  = $clog2(GRID_W);
    localparam int unsigned YW  = $clog2(GRID_H);
    localparam int unsigned PW  = $clog2(GRID_W * GRID_H + 1);
    localparam int unsigned DW  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int unsigned RPW = $clog2(GRID_W + 1);

    state_t            state, state_next;
    logic [GRID_W-1:0] cur [GRID_H];
    logic [GRID_W-1:0] nxt [GRID_H];
    logic [YW-1:0]     row;
    logic [DW-1:0]     divider;
    logic [PW-1:0]     acc;
    logic              wrap_q;
    logic [8:0]        birth_sel, surv_sel;
    logic              start_c;
    logic              wr_x_ok, wr_y_ok, rd_x_ok, rd_y_ok;
    logic [GRID_W-1:0] up_row, mid_row, down_row, row_next;
    logic [RPW-1:0]    row_pop;

    // Coordinate range checks; a power-of-two dimension can never be out of range.
    if (GRID_W == (1 << XW)) begin : g_x_full
        assign wr_x_ok = 1'b1;
        assign rd_x_ok = 1'b1;
    end else begin : g_x_part
        assign wr_x_ok = 32'(wr_x) < GRID_W;
        assign rd_x_ok = 32'(rd_x) < GRID_W;
    end
    if (GRID_H == (1 << YW)) begin : g_y_full
        assign wr_y_ok = 1'b1;
        assign rd_y_ok = 1'b1;
    end else begin : g_y_part
        assign wr_y_ok = 32'(wr_y) < GRID_H;
        assign rd_y_ok = 32'(rd_y) < GRID_H;
    end

    assign rd_cell = (rd_x_ok && rd_y_ok) ? cur[rd_y][rd_x] : 1'b0;

`ifdef LIFE_RULE_EN
    // Rule masks captured at start so a whole sweep uses one rule.
    always_ff @(posedge clk) begin
        if (rst) begin
            birth_sel <= LIFE_BIRTH_DEFAULT;
            surv_sel  <= LIFE_SURV_DEFAULT;
        end else if (start_c) begin
            birth_sel <= birth_mask;
            surv_sel  <= surv_mask;
        end
    end
`else
    assign birth_sel = LIFE_BIRTH_DEFAULT;
    assign surv_sel  = LIFE_SURV_DEFAULT;
`endif

    // Neighbour rows for the row being swept; off-grid rows wrap or read dead.
    always_comb begin
        mid_row  = cur[row];
        up_row   = '0;
        down_row = '0;
        if (row == '0) begin
            if (wrap_q) up_row = cur[GRID_H-1];
        end else begin
            up_row = cur[row - YW'(1)];
        end
        if (row == YW'(GRID_H - 1)) begin
            if (wrap_q) down_row = cur[0];
        end else begin
            down_row = cur[row + YW'(1)];
        end
    end

    life_row_next #(.GRID_W(GRID_W)) u_row (
        .up         (up_row),
        .mid        (mid_row),
        .down       (down_row),
        .wrap       (wrap_q),
        .birth_mask (birth_sel),
        .surv_mask  (surv_sel),
        .next_row   (row_next),
        .pop_count  (row_pop)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state; a start only happens when neither clear nor a write claims the cycle.
    always_comb begin
        state_next = state;
        start_c    = 1'b0;
        case (state)
            IDLE: begin
                if (!clear && !wr_en &&
                    (step || (run && divider == DW'(STEP_DIV - 1)))) begin
                    start_c    = 1'b1;
                    state_next = SWEEP;
                end
            end
            SWEEP:   if (row == YW'(GRID_H - 1)) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Grid, counters, sweep datapath and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur        <= '{default: '0};
            nxt        <= '{default: '0};
            row        <= '0;
            divider    <= '0;
            acc        <= '0;
            wrap_q     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            gen_count  <= '0;
            population <= '0;
        end else begin
            busy <= (state_next != IDLE);
            done <= (state == COMMIT);
            case (state)
                IDLE: begin
                    // Divider saturates so a start blocked by clear/write fires next cycle.
                    if (!run || start_c)                     divider <= '0;
                    else if (divider != DW'(STEP_DIV - 1))   divider <= divider + DW'(1);
                    if (clear) begin
                        cur        <= '{default: '0};
                        gen_count  <= '0;
                        population <= '0;
                    end else if (wr_en) begin
                        if (wr_x_ok && wr_y_ok) cur[wr_y][wr_x] <= wr_val;
                    end else if (start_c) begin
                        wrap_q <= wrap;
                        row    <= '0;
                        acc    <= '0;
                    end
                end
                SWEEP: begin
                    nxt[row] <= row_next;
                    acc      <= acc + PW'(row_pop);
                    row      <= (row == YW'(GRID_H - 1)) ? '0 : row + YW'(1);
                end
                COMMIT: begin
                    cur        <= nxt;
                    gen_count  <= gen_count + GEN_W'(1);
                    population <= acc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_life_engine.sv
// tb_life_engine: self-checking bench for life_engine with a cell-array reference model.
`timescale 1ns/1ps
module tb_life_engine;
    localparam int W  = 32;
    localparam int H  = 24;
    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        rst, step, run, wrap, clear, wr_en, wr_val;
    logic [4:0]  wr_x, wr_y, rd_x, rd_y;
    logic        rd_cell, busy, done;
    logic [15:0] gen_count;
    logic [9:0]  population;
`ifdef LIFE_RULE_EN
    logic [8:0]  birth_mask, surv_mask;
`endif
    logic        s_step, s_rd_cell, s_busy, s_done;
    logic [3:0]  s_gen, s_pop;

    int errors = 0;
    int checks = 0;
    bit mdl [H][W];
    int exp_gen = 0;
    bit [8:0] m_birth = 9'b000001000;
    bit [8:0] m_surv  = 9'b000001100;

    typedef struct packed {
        logic [2:0]      n;
        logic [3:0][5:0] xs;
        logic [3:0][5:0] ys;
        logic            w;
        logic [9:0]      pop;
        logic [5:0]      px;
        logic [5:0]      py;
        logic            pv;
    } vec_t;
    vec_t vecs [7];

    always #5 clk = ~clk;

    life_engine #(.GRID_W(W), .GRID_H(H), .GEN_W(16), .STEP_DIV(SD)) u_dut (
        .clk(clk), .rst(rst), .step(step), .run(run), .wrap(wrap), .clear(clear),
        .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_val(wr_val), .rd_x(rd_x), .rd_y(rd_y),
`ifdef LIFE_RULE_EN
        .birth_mask(birth_mask), .surv_mask(surv_mask),
`endif
        .rd_cell(rd_cell), .busy(busy), .done(done), .gen_count(gen_count),
        .population(population));

    life_engine #(.GRID_W(4), .GRID_H(3), .GEN_W(4), .STEP_DIV(1)) u_dut4 (
        .clk(clk), .rst(rst), .step(s_step), .run(1'b0), .wrap(1'b0), .clear(1'b0),
        .wr_en(1'b0), .wr_x(2'd0), .wr_y(2'd0), .wr_val(1'b0), .rd_x(2'd0), .rd_y(2'd0),
`ifdef LIFE_RULE_EN
        .birth_mask(9'b000001000), .surv_mask(9'b000001100),
`endif
        .rd_cell(s_rd_cell), .busy(s_busy), .done(s_done), .gen_count(s_gen),
        .population(s_pop));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input int n, input int x0, input int y0, input int x1,
                                 input int y1, input int x2, input int y2, input int x3,
                                 input int y3, input bit w, input int pop, input int px,
                                 input int py, input bit pv);
        vec_t v;
        v.n = 3'(n);
        v.xs[0] = 6'(x0); v.ys[0] = 6'(y0);
        v.xs[1] = 6'(x1); v.ys[1] = 6'(y1);
        v.xs[2] = 6'(x2); v.ys[2] = 6'(y2);
        v.xs[3] = 6'(x3); v.ys[3] = 6'(y3);
        v.w = w; v.pop = 10'(pop);
        v.px = 6'(px); v.py = 6'(py); v.pv = pv;
        return v;
    endfunction

    // Live neighbours of (x,y) in the model grid under the given edge mode.
    function automatic int nbrs(input int x, input int y, input bit w);
        int n = 0;
        int xx, yy;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                if (dx == 0 && dy == 0) continue;
                yy = y + dy;
                xx = x + dx;
                if (w) begin
                    yy = (yy + H) % H;
                    xx = (xx + W) % W;
                end else if (yy < 0 || yy >= H || xx < 0 || xx >= W) begin
                    continue;
                end
                n += int'(mdl[yy][xx]);
            end
        end
        return n;
    endfunction

    function automatic int model_pop();
        int p = 0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                p += int'(mdl[y][x]);
        return p;
    endfunction

    task automatic model_step(input bit w);
        bit tmp [H][W];
        int n;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                n = nbrs(x, y, w);
                tmp[y][x] = mdl[y][x] ? m_surv[n] : m_birth[n];
            end
        end
        mdl = tmp;
        exp_gen = (exp_gen + 1) % 65536;
    endtask

    task automatic check_grid(input string name);
        int diffs = 0;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                rd_x = 5'(x);
                rd_y = 5'(y);
                #1;
                if (rd_cell !== mdl[y][x]) diffs++;
            end
        end
        chk(name, diffs, 0);
    endtask

    task automatic load_cell(input int x, input int y, input bit v);
        wr_en = 1'b1; wr_x = 5'(x); wr_y = 5'(y); wr_val = v;
        tick();
        wr_en = 1'b0;
        if (x < W && y < H) mdl[y][x] = v;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                mdl[y][x] = 1'b0;
        exp_gen = 0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk({name, "_done"}, done, 1);
    endtask

    task automatic do_step(input bit w, input string name);
        wrap = w;
        step = 1'b1;
        tick();
        step = 1'b0;
        wait_done(name);
        model_step(w);
        chk({name, "_gen"}, gen_count, exp_gen);
        chk({name, "_pop"}, population, model_pop());
        check_grid({name, "_grid"});
    endtask

    initial begin
        int busy_cnt, done_at, done_cnt, t, last, nd, n, hits;
        rst = 1'b1; step = 1'b0; run = 1'b0; wrap = 1'b0; clear = 1'b0;
        wr_en = 1'b0; wr_val = 1'b0; wr_x = '0; wr_y = '0; rd_x = '0; rd_y = '0;
        s_step = 1'b0;
`ifdef LIFE_RULE_EN
        birth_mask = m_birth; surv_mask = m_surv;
`endif
        vecs[0] = mkv(3, 5, 4, 6, 4, 7, 4, 0, 0, 1'b0, 3, 6, 3, 1'b1);
        vecs[1] = mkv(4, 0, 0, 31, 0, 0, 23, 31, 23, 1'b1, 4, 31, 23, 1'b1);
        vecs[2] = mkv(4, 0, 0, 31, 0, 0, 23, 31, 23, 1'b0, 0, 0, 0, 1'b0);
        vecs[3] = mkv(1, 10, 10, 0, 0, 0, 0, 0, 0, 1'b0, 0, 10, 10, 1'b0);
        vecs[4] = mkv(4, 1, 1, 2, 1, 1, 2, 2, 2, 1'b0, 4, 2, 2, 1'b1);
        vecs[5] = mkv(3, 3, 3, 4, 3, 3, 4, 0, 0, 1'b0, 4, 4, 4, 1'b1);
        vecs[6] = mkv(3, 0, 22, 0, 23, 0, 0, 0, 0, 1'b1, 3, 31, 23, 1'b1);

        repeat (3) tick();
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_gen", gen_count, 0);
        chk("rst_pop", population, 0);
        check_grid("rst_grid");

        // Table of one-step patterns with hand-derived population and a probe cell.
        for (int i = 0; i < 7; i++) begin
            do_clear();
            for (int k = 0; k < int'(vecs[i].n); k++)
                load_cell(int'(vecs[i].xs[k]), int'(vecs[i].ys[k]), 1'b1);
            do_step(vecs[i].w, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_tpop", i), population, vecs[i].pop);
            rd_x = 5'(vecs[i].px); rd_y = 5'(vecs[i].py);
            #1;
            chk($sformatf("vec%0d_probe", i), rd_cell, vecs[i].pv);
        end

        // Blinker: busy length, done latency, out-of-range read and write.
        do_clear();
        load_cell(5, 4, 1'b1); load_cell(6, 4, 1'b1); load_cell(7, 4, 1'b1);
        load_cell(10, 28, 1'b1);
        rd_x = 5'd6; rd_y = 5'd28;
        #1;
        chk("oor_read", rd_cell, 0);
        wrap = 1'b0;
        step = 1'b1;
        tick();
        step = 1'b0;
        busy_cnt = 0; done_at = -1; done_cnt = 0;
        for (int c = 1; c <= 40; c++) begin
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
            tick();
        end
        chk("blink_busy_len", busy_cnt, H + 1);
        chk("blink_done_at", done_at, H + 2);
        chk("blink_done_cnt", done_cnt, 1);
        model_step(1'b0);
        chk("blink_pop", population, 3);
        chk("blink_gen", gen_count, 1);
        check_grid("blink_grid");

        // Clear wins over a simultaneous write.
        clear = 1'b1; wr_en = 1'b1; wr_x = 5'd7; wr_y = 5'd7; wr_val = 1'b1;
        tick();
        clear = 1'b0; wr_en = 1'b0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                mdl[y][x] = 1'b0;
        exp_gen = 0;
        chk("clr_gen", gen_count, 0);
        chk("clr_pop", population, 0);
        check_grid("clr_prio_grid");

        // Edits and requests during a sweep are dropped.
        load_cell(5, 4, 1'b1); load_cell(6, 4, 1'b1); load_cell(7, 4, 1'b1);
        wrap = 1'b0;
        step = 1'b1;
        tick();
        step = 1'b0;
        repeat (3) tick();
        clear = 1'b1; wr_en = 1'b1; wr_x = 5'd3; wr_y = 5'd3; wr_val = 1'b1; step = 1'b1;
        tick();
        clear = 1'b0; wr_en = 1'b0; step = 1'b0;
        wait_done("blk");
        model_step(1'b0);
        chk("blk_gen", gen_count, exp_gen);
        chk("blk_pop", population, model_pop());
        check_grid("blk_grid");
        repeat (3) tick();
        chk("blk_no_queue", busy, 0);

        // Reset in the middle of a sweep discards the generation.
        step = 1'b1;
        tick();
        step = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_gen", gen_count, 0);
        chk("mid_rst_pop", population, 0);
        done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (done === 1'b1) done_cnt++;
            tick();
        end
        chk("mid_rst_no_done", done_cnt, 0);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                mdl[y][x] = 1'b0;
        exp_gen = 0;
        check_grid("mid_rst_grid");

        // Generation counter wraps on a narrow instance.
        for (int i = 1; i <= 16; i++) begin
            s_step = 1'b1;
            tick();
            s_step = 1'b0;
            n = 0;
            while (s_done !== 1'b1 && n < 50) begin
                tick();
                n++;
            end
            chk($sformatf("gen4_done%0d", i), s_done, 1);
            if (i == 1)  chk("gen4_first", s_gen, 1);
            if (i == 15) chk("gen4_max", s_gen, 15);
        end
        chk("gen4_wrap", s_gen, 0);
        chk("gen4_pop", s_pop, 0);
        chk("gen4_cell", s_rd_cell, 0);
        tick();
        chk("gen4_idle", s_busy, 0);

        // Free-run with a glider: fixed period, diagonal drift, stops when run drops.
        do_clear();
        load_cell(11, 10, 1'b1); load_cell(12, 11, 1'b1); load_cell(10, 12, 1'b1);
        load_cell(11, 12, 1'b1); load_cell(12, 12, 1'b1);
        wrap = 1'b0;
        run = 1'b1;
        t = 0; last = -1; nd = 0;
        while (nd < 4 && t < 400) begin
            tick();
            t++;
            if (done === 1'b1) begin
                if (last >= 0) chk("run_period", t - last, SD + H + 1);
                last = t;
                nd++;
                model_step(1'b0);
            end
        end
        run = 1'b0;
        chk("run_done_count", nd, 4);
        chk("run_gen", gen_count, 4);
        chk("run_pop", population, 5);
        rd_x = 5'd12; rd_y = 5'd11; #1; hits  = int'(rd_cell);
        rd_x = 5'd13; rd_y = 5'd12; #1; hits += int'(rd_cell);
        rd_x = 5'd11; rd_y = 5'd13; #1; hits += int'(rd_cell);
        rd_x = 5'd12; rd_y = 5'd13; #1; hits += int'(rd_cell);
        rd_x = 5'd13; rd_y = 5'd13; #1; hits += int'(rd_cell);
        chk("glider_shift", hits, 5);
        check_grid("run_grid");
        done_cnt = 0;
        for (int c = 0; c < 80; c++) begin
            if (done === 1'b1) done_cnt++;
            tick();
        end
        chk("run_stop", done_cnt, 0);

        // Random soups against the model, including ignored off-grid writes.
        for (int it = 0; it < 5; it++) begin
            bit w;
            do_clear();
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++)
                    if ($urandom_range(0, 99) < 35) load_cell(x, y, 1'b1);
            for (int k = 0; k < 12; k++)
                load_cell(int'($urandom_range(0, W - 1)), int'($urandom_range(0, H + 7)),
                          1'($urandom_range(0, 1)));
            w = 1'($urandom_range(0, 1));
            n = int'($urandom_range(1, 3));
            for (int s = 0; s < n; s++)
                do_step(w, $sformatf("rnd%0d_%0d", it, s));
        end

`ifdef LIFE_RULE_EN
        // B2 rule on an isolated pair: four births, pair dies.
        m_birth = 9'b000000100;
        birth_mask = m_birth;
        do_clear();
        load_cell(5, 5, 1'b1);
        load_cell(6, 5, 1'b1);
        do_step(1'b0, "b2");
        chk("b2_tpop", population, 4);
        rd_x = 5'd5; rd_y = 5'd4; #1;
        chk("b2_birth", rd_cell, 1);
        m_birth = 9'b000001000;
        birth_mask = m_birth;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/life_engine.md
Name: life_engine

Overview:
- Parametrised Game-of-Life generation engine for the FPGA life demo; generalises the fixed top-level into a reusable core.
- Holds a GRID_W x GRID_H cell array and computes the next generation one row per cycle into a shadow array, then commits.
- Supports bounded or toroidal edges, single-step or free-run, cell editing, and a generation counter and population count for the seven-segment display.
- Read port is consumed by the VGA renderer.

Parameters:
- GRID_W, 32, grid columns (>=3)
- GRID_H, 24, grid rows (>=3)
- GEN_W, 16, generation counter width
- STEP_DIV, 4, idle cycles between generations in run mode (>=1)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- step  in  1  single-cycle request for one generation
- run  in  1  free-run enable
- wrap  in  1  1 = toroidal edges, 0 = dead border; sampled at start
- clear  in  1  zero the grid and counters (idle only)
- wr_en  in  1  cell write strobe (idle only)
- wr_x  in  $clog2(GRID_W)  write column
- wr_y  in  $clog2(GRID_H)  write row
- wr_val  in  1  value to write
- rd_x  in  $clog2(GRID_W)  read column
- rd_y  in  $clog2(GRID_H)  read row
- rd_cell  out  1  combinational read of the committed grid
- busy  out  1  generation in progress
- done  out  1  one-cycle pulse after commit
- gen_count  out  GEN_W  generations committed
- population  out  $clog2(GRID_W*GRID_H+1)  live cells in the committed grid

Behaviour:
- Reset: cur and nxt arrays all 0; state IDLE; busy=0, done=0, gen_count=0, population=0, divider=0, row=0.
- Reset has the same effect mid-SWEEP or mid-COMMIT; no partial generation survives.
- States: IDLE, SWEEP, COMMIT.
- IDLE input priority: clear > wr_en > start.
  - clear: cur=0, gen_count=0, population=0.
  - wr_en: cur[wr_y][wr_x]=wr_val; out-of-range coordinates are ignored. population is not updated until the next commit.
  - start: step=1, or run=1 with divider==STEP_DIV-1. On start: latch wrap (and rule masks), row=0, accumulator=0, divider=0, go to SWEEP.
- Divider: increments each IDLE cycle while run=1; held at 0 while run=0.
- SWEEP:
  - Each cycle, nxt[row] = rule(cur[row-1], cur[row], cur[row+1]) and accumulator += popcount(nxt[row]).
  - wrap=0: rows/columns outside the grid read as 0. wrap=1: indices wrap modulo GRID_H/GRID_W.
  - After row GRID_H-1, go to COMMIT.
- COMMIT (one cycle): cur=nxt, gen_count+=1 (wraps mod 2^GEN_W), population=accumulator, then IDLE.
- busy is registered: high for exactly GRID_H+1 cycles, starting the cycle after start is sampled.
- done: one-cycle pulse in the first IDLE cycle after COMMIT, i.e. GRID_H+1 cycles after the start edge.
- Run-mode period: STEP_DIV+GRID_H+1 cycles.
- While busy, step/clear/wr_en are ignored (not queued).
- rd_cell returns cur; out-of-range rd_x/rd_y return 0. During SWEEP, reads return the previous generation.
- Default rule B3/S23: a cell is born with exactly 3 live neighbours and survives with 2 or 3.

Optional Feature:
- Macro LIFE_RULE_EN.
- Defined: adds inputs birth_mask[8:0] and surv_mask[8:0], latched at start. Next state = cell ? surv_mask[n] : birth_mask[n], where n is the neighbour count 0..8.
- Undefined: ports absent; masks fixed at birth=9'b000001000, surv=9'b000001100 (B3/S23).

Decomposition:
- Package life_pkg: state enum {IDLE, SWEEP, COMMIT}; constants LIFE_BIRTH_DEFAULT and LIFE_SURV_DEFAULT.
- Sub-module life_row_next: combinational, GRID_W-parametrised. Inputs: up/mid/down rows, wrap, masks. Outputs: next row and its popcount.

Test Plan:
- Bounded blinker: 32x24, wrap=0, cells (5,4),(6,4),(7,4), pulse step -> busy high 25 cycles; done 25 cycles after step; grid (6,3),(6,4),(6,5); population=3; gen_count=1.
- Corner block: cells (0,0),(31,0),(0,23),(31,23). wrap=1, step -> unchanged, population=4. Repeat with wrap=0 -> all dead, population=0.
- Run mode: STEP_DIV=4, run=1 with glider loaded -> done every 29 cycles; glider translates (+1,+1) every 4 generations; drop run -> no further done.
- Busy blocking: pulse clear and wr_en (3,3)=1 during SWEEP -> grid and gen_count unaffected after commit.
- Reset mid-SWEEP: rst at row 10 -> next cycle busy=0, gen_count=0, all rd_cell=0, done never pulses.
- Counter wrap: GEN_W=4, 16 steps on an empty grid -> gen_count returns to 0. With LIFE_RULE_EN, birth=9'b000000100 (B2) on a single isolated pair -> births appear per B2.
